// File: rtl/loop_count_stage.sv
// loop_count_stage: registered down-counter stage paired with an external 8-bit Decrement block.
// Optional macro LOOP_COUNT_RELOAD_EN: the terminal Step reloads the start count and stays in RUN.
module loop_count_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] CountIn,
    input  logic             Step,
    input  logic             Abort,
    input  logic [WIDTH-1:0] DecIn,
    output logic [WIDTH-1:0] DecOut,
    output logic [WIDTH-1:0] Count,
    output logic             Busy,
    output logic             Zero,
    output logic             Done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
`ifdef LOOP_COUNT_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             pulse_q, pulse_d;
`endif

    // Next-state and next-count; RUN always holds Count>=1, so the decrement never wraps.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
`ifdef LOOP_COUNT_RELOAD_EN
        reload_d = reload_q;
        pulse_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: if (Load) begin
                count_d = CountIn;
                state_d = (CountIn == '0) ? S_DONE : S_RUN;
`ifdef LOOP_COUNT_RELOAD_EN
                reload_d = (CountIn == '0) ? reload_q : CountIn;
`endif
            end
            S_RUN: if (Abort) begin
                count_d = '0;
                state_d = S_IDLE;
            end else if (Step) begin
`ifdef LOOP_COUNT_RELOAD_EN
                count_d = (count_q == WIDTH'(1)) ? reload_q : DecIn;
                pulse_d = (count_q == WIDTH'(1));
`else
                count_d = DecIn;
                state_d = (count_q == WIDTH'(1)) ? S_DONE : S_RUN;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset taking priority over every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
`ifdef LOOP_COUNT_RELOAD_EN
            reload_q <= '0;
            pulse_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
`ifdef LOOP_COUNT_RELOAD_EN
            reload_q <= reload_d;
            pulse_q  <= pulse_d;
`endif
        end
    end

    assign Count  = count_q;
    assign DecOut = count_q;
    assign Zero   = (count_q == '0);
    assign Busy   = (state_q == S_RUN);
`ifdef LOOP_COUNT_RELOAD_EN
    assign Done   = (state_q == S_DONE) | pulse_q;
`else
    assign Done   = (state_q == S_DONE);
`endif
endmodule
